// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants, types and arithmetic helpers used by the
// add-compare-select path-metric array.
package viterbi_pkg;

    localparam int K_DEF    = 3;
    localparam int PM_W_DEF = 6;
    localparam int N_ST     = 2 ** (K_DEF - 1);

    typedef logic [PM_W_DEF-1:0] pm_t;

    // Codeword bit for generator g; u is the newest input bit above p_w state bits.
    function automatic logic parity_cw(input int unsigned g, input int unsigned u,
                                       input int unsigned p, input int unsigned p_w);
        int unsigned taps;
        taps = g & ((u << p_w) | p);
        return ^taps;
    endfunction

    // Unsigned add clamped to the largest w-bit value instead of wrapping.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned w);
        logic [63:0] sum;
        logic [63:0] max_v;
        sum   = 64'(a) + 64'(b);
        max_v = (64'd1 << w) - 64'd1;
        return (sum > max_v) ? 32'(max_v) : 32'(sum);
    endfunction

endpackage

// File: rtl/acs_pm_array_acs_cell.sv
// One add-compare-select cell: two saturating candidate sums and a select that
// keeps the even predecessor on a tie.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6,
    parameter int BM_W = 2
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    output logic [PM_W-1:0] cand_min,
    output logic            dec
);

    logic [PM_W-1:0] cand0_s;
    logic [PM_W-1:0] cand1_s;

    assign cand0_s = PM_W'(sat_add(32'(pm0), 32'(bm0), PM_W));
    assign cand1_s = PM_W'(sat_add(32'(pm1), 32'(bm1), PM_W));

    // Strictly smaller odd-predecessor candidate wins; equality stays with p0.
    always_comb begin
        if (cand1_s < cand0_s) begin
            cand_min = cand1_s;
            dec      = 1'b1;
        end else begin
            cand_min = cand0_s;
            dec      = 1'b0;
        end
    end

endmodule

// File: rtl/acs_pm_array.sv
// Registered add-compare-select array: holds every trellis path metric and
// updates them once per accepted branch-metric set, with normalisation.
module acs_pm_array
    import viterbi_pkg::*;
#(
    parameter int          K       = 3,
    parameter int unsigned G0      = 32'o7,
    parameter int unsigned G1      = 32'o5,
    parameter int          BM_W    = 2,
    parameter int          PM_W    = 6,
    parameter int unsigned INIT_PM = 32'd16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_bm_valid,
    input  logic [4*BM_W-1:0]             i_bm,
    output logic                          o_valid,
    output logic [(2**(K-1))*PM_W-1:0]    o_pm,
    output logic [(2**(K-1))-1:0]         o_dec,
    output logic [K-2:0]                  o_best_state,
    output logic                          o_norm
);

    localparam int NUM_ST = 2 ** (K - 1);
    localparam int SW     = K - 1;

    logic [PM_W-1:0]   pm_r       [NUM_ST];
    logic [PM_W-1:0]   cand_min_s [NUM_ST];
    logic [PM_W-1:0]   new_pm_s   [NUM_ST];
    logic [NUM_ST-1:0] dec_s;
    logic              all_msb_s;
    logic [SW-1:0]     best_s;
    logic [PM_W-1:0]   best_pm_s;

    for (genvar s = 0; s < NUM_ST; s++) begin : g_acs
        // Next state s = {u, p[SW-1:1]}; its predecessors differ only in the oldest bit.
        localparam int U_I  = s >> (SW - 1);
        localparam int P0_I = (s << 1) % NUM_ST;
        localparam int P1_I = P0_I + 1;
        localparam int IDX0 = 2 * int'(parity_cw(G0, U_I, P0_I, SW)) + int'(parity_cw(G1, U_I, P0_I, SW));
        localparam int IDX1 = 2 * int'(parity_cw(G0, U_I, P1_I, SW)) + int'(parity_cw(G1, U_I, P1_I, SW));

        acs_cell #(
            .PM_W (PM_W),
            .BM_W (BM_W)
        ) u_cell (
            .pm0      (pm_r[P0_I]),
            .pm1      (pm_r[P1_I]),
            .bm0      (i_bm[IDX0*BM_W +: BM_W]),
            .bm1      (i_bm[IDX1*BM_W +: BM_W]),
            .cand_min (cand_min_s[s]),
            .dec      (dec_s[s])
        );

        assign o_pm[s*PM_W +: PM_W] = pm_r[s];
    end

    // Normalise when every new metric has its MSB set, then find the lowest-index minimum.
    always_comb begin
        all_msb_s = 1'b1;
        best_s    = '0;
        for (int s = 0; s < NUM_ST; s++) begin
            all_msb_s = all_msb_s & cand_min_s[s][PM_W-1];
        end
        for (int s = 0; s < NUM_ST; s++) begin
            new_pm_s[s] = all_msb_s ? {1'b0, cand_min_s[s][PM_W-2:0]} : cand_min_s[s];
        end
        best_pm_s = new_pm_s[0];
        for (int s = 1; s < NUM_ST; s++) begin
            best_s    = (new_pm_s[s] < best_pm_s) ? SW'(s) : best_s;
            best_pm_s = (new_pm_s[s] < best_pm_s) ? new_pm_s[s] : best_pm_s;
        end
    end

    // Metric register file and output registers; start reloads the frame metrics and wins over valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_ST; s++) begin
                pm_r[s] <= (s == 0) ? '0 : PM_W'(INIT_PM);
            end
            o_dec        <= '0;
            o_valid      <= 1'b0;
            o_best_state <= '0;
            o_norm       <= 1'b0;
        end else if (i_start) begin
            for (int s = 0; s < NUM_ST; s++) begin
                pm_r[s] <= (s == 0) ? '0 : PM_W'(INIT_PM);
            end
            o_dec        <= '0;
            o_valid      <= 1'b0;
            o_best_state <= '0;
            o_norm       <= 1'b0;
        end else if (i_bm_valid) begin
            pm_r         <= new_pm_s;
            o_dec        <= dec_s;
            o_valid      <= 1'b1;
            o_best_state <= best_s;
            o_norm       <= all_msb_s;
        end else begin
            o_valid      <= 1'b0;
            o_norm       <= 1'b0;
        end
    end

endmodule
